xor_serial_arbiter: RTL
=======================

# xor_serial_arbiter

Shares one bit-serial `xor_gate` datapath between two requesters, so wide XOR operations run on a single 1-bit NAND-built XOR cell.
- A round-robin arbiter selects a requester and captures its operands.
- The block then sequences the shared cell across WIDTH cycles and returns the result with a one-cycle acknowledge pulse.
- It sits between requesting logic and the gate-level XOR cell, and is the sole driver of that cell's inputs.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inReq` in 2: per-requester request. Hold high, with operands and mode stable, until the matching `outAck` bit pulses.
- `inOpA` in 2*WIDTH: operand A; requester i uses `[i*WIDTH +: WIDTH]`.
- `inOpB` in 2*WIDTH: operand B; same packing as `inOpA`.
- `inMode` in 2: per requester; 0 = bitwise A^B, 1 = parity of A^B (only when the parity feature is compiled in).
- `outAck` out 2: one-hot, one-cycle pulse; bit i marks requester i's result valid.
- `outResult` out WIDTH: result. Valid in the `outAck` cycle; holds its value until the next DONE.
- `outBusy` out 1: high while in SHIFT or DONE.
- `outOwner` out 1: index of the requester being served; holds its last value in IDLE.

## Operation
- Exactly one `xor_gate` instance is used. Its inputs are `opA_q[cnt]` and `opB_q[cnt]`.
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one `inReq` bit is high, grant it.
  - If both bits are high, grant the requester that is not `last` (the last-served index).
  - On grant, capture that requester's A, B and mode. Set `cnt`=0, clear the result register, set `outOwner` to the grantee, and go to SHIFT.
- **SHIFT** (each cycle)
  - XOR mode: write `res[cnt]` = gate output.
  - Parity mode: `res[0]` ^= gate output; `res[WIDTH-1:1]` stays 0.
  - If `cnt`==WIDTH-1, go to DONE; otherwise increment `cnt`.
- **DONE**
  - Assert `outAck[outOwner]` for exactly one cycle.
  - `outResult` = `res`.
  - Set `last` = `outOwner`, then go to IDLE.
- The counter is $clog2(WIDTH) bits wide and never wraps inside a transaction.
- `inReq` dropping mid-transaction is ignored: the operation completes and still acks. Operand changes after capture are ignored.
- A request still high in the IDLE cycle after its ack is treated as a new transaction.
- Reset values: state=IDLE, `cnt`=0, `outAck`=0, `outResult`=0, `outBusy`=0, `outOwner`=0, `last`=1 (requester 0 wins the first tie).
- Reset mid-transaction aborts it: no ack is issued, all registers return to reset values the next cycle, and the captured request is lost.

## Timing
- The request is sampled at IDLE edge T.
- SHIFT runs for cycles T+1..T+WIDTH.
- `outAck` is high in cycle T+WIDTH+1.
- Latency from request to ack: WIDTH+1 cycles. Throughput: one transaction per WIDTH+2 cycles.
- Back-to-back case with both requests held: ack0 at cycle WIDTH+1, ack1 at cycle 2*WIDTH+3.
- Requesters drop `inReq` at the edge after they see `outAck`.
- `outAck` is never asserted in the same cycle as a grant.

## Configuration
- `XOR_ARB_PARITY_EN` defined: `inMode` is honoured and parity mode is available.
- Not defined:
  - `inMode` is ignored and every transaction is bitwise XOR.
  - The parity accumulate path and captured-mode register are removed.
  - Timing is identical in both builds.

## Test plan
- **Reset then single XOR:** reset, then requester 0 with A=0xA5, B=0x3C, mode 0 (WIDTH=8). Require `outAck`=01 exactly 9 cycles after grant, `outResult`=0x99, and `outBusy` high for 9 cycles.
- **Parity** (`XOR_ARB_PARITY_EN` defined):
  - Requester 1 with A=0xA5, B=0x3C, mode 1: `outResult`=0x00, `outAck`=10.
  - Then A=0x01, B=0x00, mode 1: `outResult`=0x01.
- **Simultaneous requests after reset:** both request. Require requester 0 acked first at cycle 9 and requester 1 acked at cycle 19. A third overlapping round then grants requester 0 again only after requester 1 has been served.
- **Reset mid-operation:** assert `rst` for 1 cycle at SHIFT `cnt`=4. Require no ack, all outputs 0 the next cycle, and a fresh request acked 9 cycles after its grant.
- **Stimulus changes after capture:** drop `inReq` and change operands to 0xFF/0xFF two cycles after grant. Require the ack still pulses with the originally captured result 0x99.

Source files
------------

// File: rtl/xor_serial_arbiter.sv
// Round-robin arbiter sharing one bit-serial NAND-built XOR cell between two requesters.
// Optional parity mode is compiled in with `define XOR_ARB_PARITY_EN.

module xor_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    logic n1, n2, n3;

    assign n1  = ~(a_i & b_i);
    assign n2  = ~(a_i & n1);
    assign n3  = ~(b_i & n1);
    assign y_o = ~(n2 & n3);
endmodule

module xor_serial_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         in_req_i,
    input  logic [2*WIDTH-1:0] in_op_a_i,
    input  logic [2*WIDTH-1:0] in_op_b_i,
    input  logic [1:0]         in_mode_i,
    output logic [1:0]         out_ack_o,
    output logic [WIDTH-1:0]   out_result_o,
    output logic               out_busy_o,
    output logic               out_owner_o
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  op_a_q, op_b_q;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  result_q;
    logic [1:0]        ack_q;
    logic              busy_q;
    logic              owner_q;
    logic              last_q;
    logic              grant_idx;
    logic              gate_a, gate_b, gate_y;
    logic              parity_mode;

`ifdef XOR_ARB_PARITY_EN
    logic mode_q;
    assign parity_mode = mode_q;
`else
    logic unused_mode;
    assign unused_mode = ^in_mode_i;
    assign parity_mode = 1'b0;
`endif

    // On a tie the requester not served last wins; otherwise the lone requester.
    assign grant_idx = (in_req_i == 2'b11) ? ~last_q : in_req_i[1];

    assign gate_a = op_a_q[cnt_q];
    assign gate_b = op_b_q[cnt_q];

    xor_gate u_xor_gate (
        .a_i (gate_a),
        .b_i (gate_b),
        .y_o (gate_y)
    );

    always_comb begin
        res_d = res_q;
        if (parity_mode) begin
            res_d[0] = res_q[0] ^ gate_y;
        end else begin
            res_d[cnt_q] = gate_y;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            result_q <= '0;
            ack_q    <= 2'b00;
            busy_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
`ifdef XOR_ARB_PARITY_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (|in_req_i) begin
                        owner_q <= grant_idx;
                        op_a_q  <= grant_idx ? in_op_a_i[2*WIDTH-1:WIDTH] : in_op_a_i[WIDTH-1:0];
                        op_b_q  <= grant_idx ? in_op_b_i[2*WIDTH-1:WIDTH] : in_op_b_i[WIDTH-1:0];
`ifdef XOR_ARB_PARITY_EN
                        mode_q  <= in_mode_i[grant_idx];
`endif
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    res_q <= res_d;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        // Result and ack are registered so both are valid in the DONE cycle.
                        result_q <= res_d;
                        ack_q    <= owner_q ? 2'b10 : 2'b01;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_ack_o    = ack_q;
    assign out_result_o = result_q;
    assign out_busy_o   = busy_q;
    assign out_owner_o  = owner_q;
endmodule
